seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 Parameter REP_W, default 4, width of the repeat-count input.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 start  input  1  request to transmit; sampled only when busy=0.
REQ-006 pattern  input  PAT_W  bit sequence; bits pattern[len-1:0] sent, pattern[len-1] first.
REQ-007 len  input  $clog2(PAT_W)+1  number of pattern bits, legal 1..PAT_W.
REQ-008 reps  input  REP_W  extra repetitions; total transmissions = reps+1.
REQ-009 x  output  1  serial data bit, one bit per clock.
REQ-010 x_valid  output  1  high in every cycle x carries a sequence bit.
REQ-011 busy  output  1  high from first bit through last bit of the last repetition.
REQ-012 done  output  1  one-cycle pulse after the final bit.
REQ-013 err  output  1  one-cycle pulse on rejected start.

Function
REQ-014 FSM states: IDLE, SEND, PAR (present only with SEQ_GEN_PARITY_EN); done is asserted in the cycle after the final bit.
REQ-015 pattern, len and reps are captured on the edge that accepts start; later input changes do not affect the transmission.
REQ-016 IDLE: start=1 with legal len -> SEND; first bit on x in the cycle after the accepting edge (1-cycle latency).
REQ-017 SEND: shift one bit per cycle; after bit 0, if repetitions remain -> reload captured pattern and resend with no idle cycle; otherwise -> IDLE (or PAR).
REQ-018 Back-to-back repetitions form a contiguous stream, so overlapping occurrences across boundaries appear on x.
REQ-019 In IDLE: x=0, x_valid=0, busy=0.
REQ-020 done pulses in the first IDLE cycle after the final bit; busy is already 0 in that cycle.
REQ-021 start in the done cycle is accepted; the next sequence begins one cycle later.
REQ-022 start while busy=1 is ignored, with no err pulse.
REQ-023 start with len=0 or len>PAT_W -> err pulses for one cycle after the edge; FSM stays in IDLE.
REQ-024 Repetition counter is REP_W bits and counts down from captured reps; no wrap beyond zero.

Reset
REQ-025 reset=0 at an edge forces IDLE; in the following cycle x, x_valid, busy, done and err are 0.
REQ-026 Reset mid-transmission aborts the transmission; done is never asserted for the aborted sequence.

Configuration
REQ-027 Macro SEQ_GEN_PARITY_EN defined: after each repetition, PAR state emits one even-parity bit over the sent bits (x_valid=1, busy=1).
REQ-028 SEQ_GEN_PARITY_EN undefined: PAR state and parity logic are absent; repetitions abut directly.

Structure
REQ-029 Package seq_gen_pkg holds PAT_W and REP_W defaults and the FSM state typedef.
REQ-030 Sub-module seq_gen_piso is the loadable parallel-in/serial-out shift register with bit counter; seq_gen holds the FSM, repeat counter and handshake.

Verification
REQ-031 pattern=4'b1011, len=4, reps=0, start at edge 0 -> x=1,0,1,1 in cycles 1-4 with x_valid=1; done=1 in cycle 5.
REQ-032 Same pattern, reps=2 -> x=101110111011 in cycles 1-12 with no gap; busy high cycles 1-12; done in cycle 13.
REQ-033 start re-pulsed in cycle 2 of REQ-031 -> ignored; output identical to REQ-031; err stays 0.
REQ-034 reset=0 at the edge ending cycle 2 -> from cycle 3: x=0, busy=0; done never pulses.
REQ-035 len=0 with start -> err=1 for one cycle; busy and x_valid stay 0.
REQ-036 SEQ_GEN_PARITY_EN defined, REQ-031 stimulus -> x=1,0,1,1,1 in cycles 1-5; done in cycle 6.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: width defaults and FSM state encoding shared by seq_gen and seq_gen_piso.
package seq_gen_pkg;
    localparam int PAT_W_DEF = 8;
    localparam int REP_W_DEF = 4;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t PAR  = 2'd2;
endpackage

// File: rtl/seq_gen_piso.sv
// seq_gen_piso: loadable MSB-first shift register; last flags the final bit of the loaded pattern.
module seq_gen_piso
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] data,
    input  logic [LEN_W-1:0] size,
    output logic             q,
    output logic             last
);
    localparam logic [LEN_W-1:0] PW = LEN_W'(PAT_W);
    logic [PAT_W-1:0] sr;
    logic [LEN_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data << (PW - size);
            cnt <= size;
        end else if (shift) begin
            sr  <= sr << 1;
            cnt <= cnt - 1'b1;
        end
    end
    assign q    = sr[PAT_W-1];
    assign last = cnt == LEN_W'(1);
endmodule

// File: rtl/seq_gen.sv
// seq_gen: repeating serial pattern generator; define SEQ_GEN_PARITY_EN to append an even-parity bit per repetition.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W):0]     len,
    input  logic [REP_W-1:0]           reps,
    output logic                       x,
    output logic                       x_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    state_t           state, nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_cnt;
    logic             legal, accept, reject, fin, reload, q, last;
    assign legal  = len != '0 && len <= LEN_W'(PAT_W);
    assign accept = state == IDLE && start && legal;
    assign reject = state == IDLE && start && !legal;
    assign reload = fin && rep_cnt != '0;
`ifdef SEQ_GEN_PARITY_EN
    logic par;
    assign par = ^(pat_q & ~({PAT_W{1'b1}} << len_q));
    always_comb begin
        fin = state == PAR;
        nxt = state == IDLE ? (accept ? SEND : IDLE)
            : state == SEND ? (last ? PAR : SEND)
            : (rep_cnt == '0 ? IDLE : SEND);
    end
    assign x = state == SEND ? q : state == PAR && par;
`else
    always_comb begin
        fin = state == SEND && last;
        nxt = state == IDLE ? (accept ? SEND : IDLE) : (fin && rep_cnt == '0 ? IDLE : SEND);
    end
    assign x = state == SEND && q;
`endif
    assign x_valid = state != IDLE;
    assign busy    = state != IDLE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_cnt <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            done  <= fin && rep_cnt == '0;
            err   <= reject;
            if (accept) begin
                pat_q   <= pattern;
                len_q   <= len;
                rep_cnt <= reps;
            end else if (reload) begin
                rep_cnt <= rep_cnt - 1'b1;
            end
        end
    end
    seq_gen_piso #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept || reload),
        .shift (state == SEND),
        .data  (accept ? pattern : pat_q),
        .size  (accept ? len : len_q),
        .q     (q),
        .last  (last)
    );
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: cycle-table and hand-sequence checks of seq_gen in its default (no parity) build.
module tb_seq_gen;
    logic clk = 0, reset = 0, start = 0;
    logic [7:0] pattern = 0;
    logic [3:0] len = 0, reps = 0;
    logic x, x_valid, busy, done, err;
    int checks = 0, errors = 0;

    typedef struct {
        logic r, s;
        logic [7:0] p;
        logic [3:0] l, n;
        logic ex, ev, eb, ed, ee;
    } vec_t;
    vec_t tbl[$];

    seq_gen dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ex, ev, eb, ed, ee);
        chk({tag, ".x"}, x, ex);
        chk({tag, ".x_valid"}, x_valid, ev);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".done"}, done, ed);
        chk({tag, ".err"}, err, ee);
    endtask

    function automatic vec_t v(input logic r, s, input logic [7:0] p, input logic [3:0] l, n,
                               input logic ex, ev, eb, ed, ee);
        vec_t t;
        t = '{r, s, p, l, n, ex, ev, eb, ed, ee};
        return t;
    endfunction

    task automatic send(input logic [7:0] p, input logic [3:0] l, r);
        @(negedge clk);
        chk_all("send.idle", 0, 0, 0, 0, 0);
        start = 1; pattern = p; len = l; reps = r;
        for (int k = 0; k <= int'(r); k++)
            for (int i = int'(l) - 1; i >= 0; i--) begin
                @(negedge clk);
                chk_all("send.bit", p[i], 1, 1, 0, 0);
                start = 0; pattern = ~p; len = 1; reps = 0;
            end
        @(negedge clk);
        chk_all("send.done", 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_all("send.after", 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl.push_back(v(1, 1, 8'h0B, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 8'hFF, 8, 3, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 8'h02, 2, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 8'h00, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 8'h00, 9, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 8'h01, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].ex, tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].ee);
            reset = tbl[i].r; start = tbl[i].s; pattern = tbl[i].p; len = tbl[i].l; reps = tbl[i].n;
        end

        send(8'h0B, 4, 2);
        send(8'hA5, 8, 0);
        send(8'h05, 3, 1);
        send(8'h01, 1, 15);

        @(negedge clk);
        start = 1; pattern = 8'h0B; len = 4; reps = 0;
        @(negedge clk);
        chk_all("rst.c1", 1, 1, 1, 0, 0);
        start = 0;
        @(negedge clk);
        chk_all("rst.c2", 0, 1, 1, 0, 0);
        reset = 0;
        @(negedge clk);
        chk_all("rst.c3", 0, 0, 0, 0, 0);
        reset = 1;
        repeat (5) begin
            @(negedge clk);
            chk_all("rst.after", 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
